alu_m_control: RTL and testbench
================================

# alu_m_control

Execute-stage ALU control with integrated RV32M/RV64M sequencer, parametrised in XLEN. It decodes opcode/func3/func7/aluop_in into the 4-bit ALU operation code for the combinational ALU. For M-extension instructions it runs an iterative shift-add multiplier / restoring divider, stalling the pipeline until the result is ready. It sits between the main decoder and the ALU/writeback mux in EX.

## Interface
- XLEN, 32, operand/result width (32 or 64)
- ENABLE_M, 1, 0 removes the sequencer; M encodings decode as ADD, never stall
---
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  instruction valid in EX
- flush  in  1  synchronous abort of any in-flight M op
- aluop_in  in  2  main-decoder class: 00 add, 01 branch, 10 R-type
- func7  in  7  instruction[31:25]
- func3  in  3  instruction[14:12]
- instruction_opcode  in  7  instruction[6:0]
- rs1_value  in  XLEN  operand A
- rs2_value  in  XLEN  operand B
- aluop_out  out  4  ALU code (combinational)
- m_op  out  1  current instruction is M-extension (combinational)
- stall  out  1  hold pipeline (combinational)
- m_result  out  XLEN  M result, valid while m_done
- m_done  out  1  one-cycle pulse, result valid

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SLTU 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, XOR 1010, SRA 1100.
- OP-IMM (0010011): func3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRA if func7[5] else SRL, 110 OR, 111 AND.
- BRANCH (1100011): beq/bne SUB; blt/bge SLT; bltu/bgeu SLTU; other func3 ADD.
- LUI/AUIPC/loads/stores/jumps/aluop_in=00: ADD.
- OP (0110011, aluop_in 10): func7 0000000 per func3 as OP-IMM (101 → SRL); func7 0100000 with 000 SUB, 101 SRA; func7 0000001 → m_op=1 (if ENABLE_M), aluop_out ADD; all else ADD.
- M func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM IDLE, MUL, DIV, DONE. IDLE & valid_in & m_op: latch operand magnitudes (signed operands per op), result-sign flag, op; counter=XLEN; → MUL or DIV, or → DONE via fast path.
- MUL: one multiplier bit per cycle into 2·XLEN accumulator; counter−1; counter==1 → DONE. Negate 2·XLEN product if sign flag; MUL takes low XLEN, MULH* high XLEN.
- DIV: restoring, one quotient bit per cycle; counter==1 → DONE. Quotient negated if operand signs differ (DIV); remainder takes dividend sign (REM).
- Fast path: divisor 0 → quotient all-ones, remainder = dividend; signed overflow (min/−1) → quotient = dividend, remainder 0.
- DONE: m_result driven, m_done=1, → IDLE unconditionally (pipeline advances this cycle; same instruction never re-accepted).
- stall = valid_in & m_op & (state != DONE).
- flush: any state → IDLE, counter 0, no m_done; flush wins over acceptance in IDLE.

## Timing
- Reset (async, rst_n=0): state IDLE, counter 0, accumulators 0, m_result 0, m_done 0; stall follows valid_in/m_op combinationally (high if M op presented).
- aluop_out, m_op: zero latency, combinational.
- Iterative op accepted at edge 0: MUL/DIV occupy XLEN cycles, DONE at cycle XLEN+1; stall high XLEN+1 cycles, low in DONE cycle.
- Fast path: stall high 1 cycle, m_done in cycle 1.
- Back-to-back M ops: second accepted in the cycle after DONE.
- m_result holds last value outside DONE; only m_done qualifies it.
- rst_n mid-operation aborts immediately; no m_done.

## Test plan
- Decode sweep: sub (10/0100000/000) → 0110; sltiu → 0011; srai (func7 0100000) → 1100; bltu → 0011; func7 0000001 with ENABLE_M=0 → 0010, m_op=0.
- XLEN=32 MUL 7 × 0xFFFFFFFD → stall 33 cycles, m_done cycle 33, m_result 0xFFFFFFEB; MULHU 0xFFFFFFFF² → 0xFFFFFFFE; MULH same → 0x00000000.
- DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- DIVU x/0 → 0xFFFFFFFF after 1 stall cycle; REM 0x80000000/−1 → 0, DIV → 0x80000000, 1 stall cycle.
- flush at cycle 10 of MUL → IDLE, no m_done; next DIVU 100/7 returns 14.
- rst_n low mid-DIV → m_done 0, m_result 0 immediately; XLEN=64 MULHU (2^64−1)² → 0xFFFFFFFFFFFFFFFE after 65 stall cycles.

Source files
------------

// File: rtl/alu_m_control_if.sv
// EX-stage bundle between the pipeline/decoder and alu_m_control:
// instruction fields and operands in, ALU code, stall and M result out.
interface alu_m_control_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_in;
    logic            flush;
    logic [1:0]      aluop_in;
    logic [6:0]      func7;
    logic [2:0]      func3;
    logic [6:0]      instruction_opcode;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [3:0]      aluop_out;
    logic            m_op;
    logic            stall;
    logic [XLEN-1:0] m_result;
    logic            m_done;

    modport master (
        output valid_in, flush, aluop_in, func7, func3, instruction_opcode, rs1_value, rs2_value,
        input  aluop_out, m_op, stall, m_result, m_done
    );

    modport slave (
        input  valid_in, flush, aluop_in, func7, func3, instruction_opcode, rs1_value, rs2_value,
        output aluop_out, m_op, stall, m_result, m_done
    );
endinterface

// File: rtl/alu_m_control.sv
// EX-stage ALU control: decodes the 4-bit ALU code and sequences RV32M/RV64M
// ops on an iterative shift-add multiplier / restoring divider.
module alu_m_control #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_m_control_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned PW = 2 * XLEN;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1100;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic [3:0] f_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [1:0]      r_op, w_op_nx;
    logic            r_neg_q, w_neg_q_nx;
    logic            r_neg_r, w_neg_r_nx;
    logic [PW-1:0]   r_opa, w_opa_nx;
    logic [XLEN-1:0] r_opb, w_opb_nx;
    logic [PW-1:0]   r_acc, w_acc_nx;
    logic [XLEN-1:0] r_m_result, w_m_result_nx;
    logic            r_m_done, w_m_done_nx;

    logic [3:0]      w_aluop;
    logic            w_m_op;

    // Instruction class decode into the ALU code
    always_comb begin
        w_aluop = ALU_ADD;
        w_m_op  = 1'b0;
        case (bus.instruction_opcode)
            OPC_OPIMM: w_aluop = f_arith(bus.func3, bus.func7[5]);
            OPC_BRANCH: begin
                case (bus.func3[2:1])
                    2'b00:   w_aluop = ALU_SUB;
                    2'b10:   w_aluop = ALU_SLT;
                    2'b11:   w_aluop = ALU_SLTU;
                    default: w_aluop = ALU_ADD;
                endcase
            end
            OPC_OP: begin
                if (bus.aluop_in == 2'b10) begin
                    if (bus.func7 == F7_BASE) begin
                        w_aluop = f_arith(bus.func3, 1'b0);
                    end else if (bus.func7 == F7_ALT) begin
                        if (bus.func3 == 3'b000)      w_aluop = ALU_SUB;
                        else if (bus.func3 == 3'b101) w_aluop = ALU_SRA;
                    end else if (bus.func7 == F7_MULDIV) begin
                        w_m_op = ENABLE_M;
                    end
                end
            end
            default: ;
        endcase
    end

    // Operand preparation for a newly accepted M op
    logic [2:0]      w_f3;
    logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div0, w_ovf;
    logic [XLEN-1:0] w_fast_res;

    always_comb begin
        w_f3     = bus.func3;
        w_is_div = w_f3[2];
        w_sgn_a  = w_f3[2] ? ~w_f3[0] : (w_f3[1:0] != 2'b11);
        w_sgn_b  = w_f3[2] ? ~w_f3[0] : ~w_f3[1];
        w_neg_a  = w_sgn_a & bus.rs1_value[XLEN-1];
        w_neg_b  = w_sgn_b & bus.rs2_value[XLEN-1];
        w_mag_a  = w_neg_a ? (XLEN'(0) - bus.rs1_value) : bus.rs1_value;
        w_mag_b  = w_neg_b ? (XLEN'(0) - bus.rs2_value) : bus.rs2_value;
        w_div0   = w_is_div && (bus.rs2_value == '0);
        w_ovf    = w_is_div && !w_f3[0] && (bus.rs1_value == MIN_NEG) && (bus.rs2_value == '1);
        if (w_div0) w_fast_res = w_f3[1] ? bus.rs1_value : '1;
        else        w_fast_res = w_f3[1] ? '0 : bus.rs1_value;
    end

    // One multiply / divide step and the sign-corrected final results
    logic [PW-1:0]   w_mul_acc, w_prod_fin;
    logic [XLEN:0]   w_rem_sh;
    logic            w_div_ge;
    logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_rem_fin, w_quo_fin, w_mul_res, w_div_res;

    always_comb begin
        w_mul_acc  = r_acc + (r_opb[0] ? r_opa : PW'(0));
        w_prod_fin = r_neg_q ? (PW'(0) - w_mul_acc) : w_mul_acc;
        w_mul_res  = (r_op == 2'b00) ? w_prod_fin[XLEN-1:0] : w_prod_fin[PW-1:XLEN];
        w_rem_sh   = {r_acc[XLEN-1:0], r_opb[XLEN-1]};
        w_div_ge   = w_rem_sh >= {1'b0, r_opa[XLEN-1:0]};
        // Remainder after subtraction is below the divisor, so XLEN bits suffice
        w_rem_nx   = w_div_ge ? (w_rem_sh[XLEN-1:0] - r_opa[XLEN-1:0]) : w_rem_sh[XLEN-1:0];
        w_quo_nx   = {r_opb[XLEN-2:0], w_div_ge};
        w_quo_fin  = r_neg_q ? (XLEN'(0) - w_quo_nx) : w_quo_nx;
        w_rem_fin  = r_neg_r ? (XLEN'(0) - w_rem_nx) : w_rem_nx;
        w_div_res  = r_op[1] ? w_rem_fin : w_quo_fin;
    end

    // Sequencer next-state and datapath update
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_op_nx       = r_op;
        w_neg_q_nx    = r_neg_q;
        w_neg_r_nx    = r_neg_r;
        w_opa_nx      = r_opa;
        w_opb_nx      = r_opb;
        w_acc_nx      = r_acc;
        w_m_result_nx = r_m_result;
        w_m_done_nx   = 1'b0;
        if (bus.flush) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_in && w_m_op) begin
                        w_op_nx    = w_f3[1:0];
                        w_neg_q_nx = w_neg_a ^ w_neg_b;
                        w_neg_r_nx = w_neg_a;
                        w_cnt_nx   = CW'(XLEN);
                        w_acc_nx   = '0;
                        if (w_div0 || w_ovf) begin
                            w_state_nx    = S_DONE;
                            w_m_result_nx = w_fast_res;
                            w_m_done_nx   = 1'b1;
                        end else if (w_is_div) begin
                            w_state_nx = S_DIV;
                            w_opa_nx   = {{XLEN{1'b0}}, w_mag_b};
                            w_opb_nx   = w_mag_a;
                        end else begin
                            w_state_nx = S_MUL;
                            w_opa_nx   = {{XLEN{1'b0}}, w_mag_a};
                            w_opb_nx   = w_mag_b;
                        end
                    end
                end
                S_MUL: begin
                    w_acc_nx = w_mul_acc;
                    w_opa_nx = r_opa << 1;
                    w_opb_nx = r_opb >> 1;
                    w_cnt_nx = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        w_state_nx    = S_DONE;
                        w_m_result_nx = w_mul_res;
                        w_m_done_nx   = 1'b1;
                    end
                end
                S_DIV: begin
                    w_acc_nx = {{XLEN{1'b0}}, w_rem_nx};
                    w_opb_nx = w_quo_nx;
                    w_cnt_nx = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        w_state_nx    = S_DONE;
                        w_m_result_nx = w_div_res;
                        w_m_done_nx   = 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_m_result <= '0;
            r_m_done   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_op       <= w_op_nx;
            r_neg_q    <= w_neg_q_nx;
            r_neg_r    <= w_neg_r_nx;
            r_opa      <= w_opa_nx;
            r_opb      <= w_opb_nx;
            r_acc      <= w_acc_nx;
            r_m_result <= w_m_result_nx;
            r_m_done   <= w_m_done_nx;
        end
    end

    assign bus.aluop_out = w_aluop;
    assign bus.m_op      = w_m_op;
    assign bus.stall     = bus.valid_in & w_m_op & (r_state != S_DONE);
    assign bus.m_result  = r_m_result;
    assign bus.m_done    = r_m_done;
endmodule

// File: tb/tb_alu_m_control.sv
// Directed bench for alu_m_control: decode table, M ops on XLEN=32/64,
// fast paths, flush, back-to-back and asynchronous reset.
module tb_alu_m_control;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_m_control_if #(.XLEN(32)) bus32 ();
    alu_m_control_if #(.XLEN(32)) busn ();
    alu_m_control_if #(.XLEN(64)) bus64 ();

    alu_m_control #(.XLEN(32), .ENABLE_M(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    alu_m_control #(.XLEN(32), .ENABLE_M(1'b0)) dutn  (.clk(clk), .rst_n(rst_n), .bus(busn));
    alu_m_control #(.XLEN(64), .ENABLE_M(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    task automatic drive(input bit wide, input logic v, input logic [6:0] opc, input logic [1:0] aop,
                         input logic [6:0] f7, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        if (wide) begin
            bus64.valid_in = v; bus64.instruction_opcode = opc; bus64.aluop_in = aop;
            bus64.func7 = f7; bus64.func3 = f3; bus64.rs1_value = a; bus64.rs2_value = b;
        end else begin
            bus32.valid_in = v; bus32.instruction_opcode = opc; bus32.aluop_in = aop;
            bus32.func7 = f7; bus32.func3 = f3; bus32.rs1_value = a[31:0]; bus32.rs2_value = b[31:0];
        end
    endtask

    // Presents an M op at posedge+1 and follows it until m_done (cycle 0 = presentation cycle)
    task automatic run_m(input bit wide, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int stalls, output int done_cyc);
        bit got = 1'b0;
        res = '0; stalls = 0; done_cyc = -1;
        drive(wide, 1'b1, OPC_OP, 2'b10, 7'b0000001, f3, a, b);
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (wide ? bus64.stall : bus32.stall) stalls++;
            if (wide ? bus64.m_done : bus32.m_done) begin
                got = 1'b1;
                done_cyc = c;
                res = wide ? bus64.m_result : {32'h0, bus32.m_result};
            end
            @(posedge clk); #1;
        end
        drive(wide, 1'b0, OPC_OP, 2'b10, 7'b0, 3'b0, 64'h0, 64'h0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus32.flush = 1'b0; busn.flush = 1'b0; bus64.flush = 1'b0;
        busn.valid_in = 1'b0; busn.instruction_opcode = '0; busn.aluop_in = '0;
        busn.func7 = '0; busn.func3 = '0; busn.rs1_value = '0; busn.rs2_value = '0;
        drive(1'b1, 1'b0, 7'b0, 2'b0, 7'b0, 3'b0, 64'h0, 64'h0);
        drive(1'b0, 1'b1, OPC_OP, 2'b10, 7'b0000001, 3'b000, 64'd3, 64'd4);
        #2;
        checks++; if (bus32.stall !== 1'b1) begin failures++; $display("FAIL reset_stall: got %b expected 1", bus32.stall); end
        checks++; if (bus32.m_done !== 1'b0) begin failures++; $display("FAIL reset_m_done: got %b expected 0", bus32.m_done); end
        checks++; if (bus32.m_result !== 32'h0) begin failures++; $display("FAIL reset_m_result: got %h expected 0", bus32.m_result); end
        drive(1'b0, 1'b0, 7'b0, 2'b0, 7'b0, 3'b0, 64'h0, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [6:0] opc; logic [1:0] aop; logic [6:0] f7; logic [2:0] f3;
        logic [3:0] exp_alu; logic exp_m; string name;
    } dec_vec_t;

    task automatic test_decode;
        dec_vec_t vec [14];
        vec = '{
            '{OPC_OP,     2'b10, 7'b0100000, 3'b000, 4'b0110, 1'b0, "sub"},
            '{OPC_OPIMM,  2'b10, 7'b0000000, 3'b011, 4'b0011, 1'b0, "sltiu"},
            '{OPC_OPIMM,  2'b10, 7'b0100000, 3'b101, 4'b1100, 1'b0, "srai"},
            '{OPC_OPIMM,  2'b10, 7'b0000000, 3'b101, 4'b1001, 1'b0, "srli"},
            '{OPC_OPIMM,  2'b10, 7'b0000000, 3'b111, 4'b0000, 1'b0, "andi"},
            '{OPC_BRANCH, 2'b01, 7'b0000000, 3'b110, 4'b0011, 1'b0, "bltu"},
            '{OPC_BRANCH, 2'b01, 7'b0000000, 3'b000, 4'b0110, 1'b0, "beq"},
            '{OPC_BRANCH, 2'b01, 7'b0000000, 3'b101, 4'b0111, 1'b0, "bge"},
            '{OPC_LUI,    2'b00, 7'b0000000, 3'b000, 4'b0010, 1'b0, "lui"},
            '{OPC_OP,     2'b10, 7'b0000000, 3'b100, 4'b1010, 1'b0, "xor"},
            '{OPC_OP,     2'b10, 7'b0100000, 3'b101, 4'b1100, 1'b0, "sra"},
            '{OPC_OP,     2'b10, 7'b0000000, 3'b001, 4'b1000, 1'b0, "sll"},
            '{OPC_OP,     2'b10, 7'b0000000, 3'b110, 4'b0001, 1'b0, "or"},
            '{OPC_OP,     2'b10, 7'b0000001, 3'b000, 4'b0010, 1'b1, "mul"}
        };
        foreach (vec[i]) begin
            drive(1'b0, 1'b0, vec[i].opc, vec[i].aop, vec[i].f7, vec[i].f3, 64'h0, 64'h0);
            busn.valid_in = 1'b1; busn.instruction_opcode = vec[i].opc; busn.aluop_in = vec[i].aop;
            busn.func7 = vec[i].f7; busn.func3 = vec[i].f3;
            #1;
            checks++; if (bus32.aluop_out !== vec[i].exp_alu) begin failures++;
                $display("FAIL dec_%s_alu: got %b expected %b", vec[i].name, bus32.aluop_out, vec[i].exp_alu); end
            checks++; if (bus32.m_op !== vec[i].exp_m) begin failures++;
                $display("FAIL dec_%s_m_op: got %b expected %b", vec[i].name, bus32.m_op, vec[i].exp_m); end
            checks++; if (busn.aluop_out !== vec[i].exp_alu || busn.m_op !== 1'b0 || busn.stall !== 1'b0) begin failures++;
                $display("FAIL nom_%s: got alu=%b m_op=%b stall=%b expected alu=%b m_op=0 stall=0",
                         vec[i].name, busn.aluop_out, busn.m_op, busn.stall, vec[i].exp_alu); end
        end
        busn.valid_in = 1'b0;
        drive(1'b0, 1'b0, 7'b0, 2'b0, 7'b0, 3'b0, 64'h0, 64'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        logic [63:0] r; int st; int dc;
        run_m(1'b0, 3'b000, 64'd7, 64'hFFFFFFFD, r, st, dc);
        checks++; if (r[31:0] !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_res: got %h expected ffffffeb", r[31:0]); end
        checks++; if (st !== 33) begin failures++; $display("FAIL mul_stall: got %0d expected 33", st); end
        checks++; if (dc !== 33) begin failures++; $display("FAIL mul_done_cycle: got %0d expected 33", dc); end
        run_m(1'b0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, r, st, dc);
        checks++; if (r[31:0] !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu_res: got %h expected fffffffe", r[31:0]); end
        run_m(1'b0, 3'b001, 64'hFFFFFFFF, 64'hFFFFFFFF, r, st, dc);
        checks++; if (r[31:0] !== 32'h0) begin failures++; $display("FAIL mulh_res: got %h expected 00000000", r[31:0]); end
        run_m(1'b0, 3'b010, 64'hFFFFFFFF, 64'd2, r, st, dc);
        checks++; if (r[31:0] !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu_res: got %h expected ffffffff", r[31:0]); end
    endtask

    task automatic test_div;
        logic [63:0] r; int st; int dc;
        run_m(1'b0, 3'b100, 64'hFFFFFFF9, 64'd2, r, st, dc);
        checks++; if (r[31:0] !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_res: got %h expected fffffffd", r[31:0]); end
        checks++; if (dc !== 33) begin failures++; $display("FAIL div_done_cycle: got %0d expected 33", dc); end
        run_m(1'b0, 3'b110, 64'hFFFFFFF9, 64'd2, r, st, dc);
        checks++; if (r[31:0] !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_res: got %h expected ffffffff", r[31:0]); end
        run_m(1'b0, 3'b101, 64'd100, 64'd7, r, st, dc);
        checks++; if (r[31:0] !== 32'd14) begin failures++; $display("FAIL divu_res: got %h expected 0000000e", r[31:0]); end
        run_m(1'b0, 3'b111, 64'd100, 64'd7, r, st, dc);
        checks++; if (r[31:0] !== 32'd2) begin failures++; $display("FAIL remu_res: got %h expected 00000002", r[31:0]); end
    endtask

    task automatic test_fast_path;
        logic [63:0] r; int st; int dc;
        run_m(1'b0, 3'b101, 64'd1234, 64'd0, r, st, dc);
        checks++; if (r[31:0] !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_res: got %h expected ffffffff", r[31:0]); end
        checks++; if (st !== 1 || dc !== 1) begin failures++; $display("FAIL divu0_timing: got stall=%0d done=%0d expected 1 1", st, dc); end
        run_m(1'b0, 3'b111, 64'd5, 64'd0, r, st, dc);
        checks++; if (r[31:0] !== 32'd5) begin failures++; $display("FAIL remu0_res: got %h expected 00000005", r[31:0]); end
        run_m(1'b0, 3'b110, 64'h80000000, 64'hFFFFFFFF, r, st, dc);
        checks++; if (r[31:0] !== 32'h0) begin failures++; $display("FAIL rem_ovf_res: got %h expected 00000000", r[31:0]); end
        run_m(1'b0, 3'b100, 64'h80000000, 64'hFFFFFFFF, r, st, dc);
        checks++; if (r[31:0] !== 32'h80000000) begin failures++; $display("FAIL div_ovf_res: got %h expected 80000000", r[31:0]); end
        checks++; if (st !== 1 || dc !== 1) begin failures++; $display("FAIL div_ovf_timing: got stall=%0d done=%0d expected 1 1", st, dc); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] r; int st; int dc;
        run_m(1'b0, 3'b101, 64'd100, 64'd7, r, st, dc);
        checks++; if (r[31:0] !== 32'd14) begin failures++; $display("FAIL b2b_first: got %h expected 0000000e", r[31:0]); end
        run_m(1'b0, 3'b000, 64'd6, 64'd7, r, st, dc);
        checks++; if (r[31:0] !== 32'd42 || dc !== 33) begin failures++;
            $display("FAIL b2b_second: got %h at cycle %0d expected 0000002a at 33", r[31:0], dc); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus32.m_result !== 32'd42 || bus32.m_done !== 1'b0) begin failures++;
            $display("FAIL result_hold: got %h done=%b expected 0000002a done=0", bus32.m_result, bus32.m_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        logic [63:0] r; int st; int dc; bit seen = 1'b0;
        drive(1'b0, 1'b1, OPC_OP, 2'b10, 7'b0000001, 3'b000, 64'd9, 64'd9);
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (bus32.stall !== 1'b1) begin failures++; $display("FAIL flush_pre_stall: got %b expected 1", bus32.stall); end
        bus32.flush = 1'b1;
        drive(1'b0, 1'b0, OPC_OP, 2'b10, 7'b0, 3'b0, 64'h0, 64'h0);
        @(posedge clk); #1;
        bus32.flush = 1'b0;
        repeat (40) begin
            #1; if (bus32.m_done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_done: got m_done seen=%b expected 0", seen); end
        run_m(1'b0, 3'b101, 64'd100, 64'd7, r, st, dc);
        checks++; if (r[31:0] !== 32'd14 || dc !== 33) begin failures++;
            $display("FAIL flush_next_divu: got %h at cycle %0d expected 0000000e at 33", r[31:0], dc); end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        drive(1'b0, 1'b1, OPC_OP, 2'b10, 7'b0000001, 3'b101, 64'd100, 64'd7);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (bus32.m_done !== 1'b0 || bus32.m_result !== 32'h0) begin failures++;
            $display("FAIL reset_mid: got done=%b result=%h expected done=0 result=0", bus32.m_done, bus32.m_result); end
        drive(1'b0, 1'b0, OPC_OP, 2'b10, 7'b0, 3'b0, 64'h0, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin
            #1; if (bus32.m_done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL reset_mid_no_done: got seen=%b expected 0", seen); end
    endtask

    task automatic test_mul64;
        logic [63:0] r; int st; int dc;
        run_m(1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, r, st, dc);
        checks++; if (r !== 64'hFFFFFFFFFFFFFFFE) begin failures++; $display("FAIL mulhu64_res: got %h expected fffffffffffffffe", r); end
        checks++; if (st !== 65 || dc !== 65) begin failures++;
            $display("FAIL mulhu64_timing: got stall=%0d done=%0d expected 65 65", st, dc); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_mul64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
